// File: rtl/free_list.sv
// ============================================================================
// Module   : free_list
// Purpose  : Physical-register free list. A circular FIFO of PREG numbers with
//            a speculative head, an architectural head and a tail, plus branch
//            rollback. Optional macro FREE_LIST_CHECK_EN adds an is_free
//            shadow vector for double-free and stale-allocation checking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module free_list #(
    parameter  int PHYS_REG_SZ = 64,
    parameter  int ARCH_REG_SZ = 32,
    localparam int PREG_W      = $clog2(PHYS_REG_SZ),
    localparam int DEPTH       = PHYS_REG_SZ - ARCH_REG_SZ,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              alloc_en_i,
    output logic [PREG_W-1:0] free_reg_o,
    output logic              free_valid_o,
    input  logic              retire_en_i,
    input  logic [PREG_W-1:0] retire_told_i,
    input  logic              rollback_i,
    output logic [CNT_W-1:0]  free_count_o,
    output logic              full_o,
    output logic              error_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PW    = PTR_W + 1;

    logic [PREG_W-1:0] fifo_q [DEPTH];
    logic [PW-1:0]     spec_head_q, spec_head_d;
    logic [PW-1:0]     arch_head_q, arch_head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic              error_q, error_d;

    logic [PW-1:0]     count;
    logic              alloc_req, alloc_take, alloc_err;
    logic              retire_err, retire_ok;
    logic              push_req, push_err, push;
    logic              check_err;

    // Occupancy is derived from the pointers; the wrap bit makes 0 and DEPTH distinct.
    assign count        = tail_q - spec_head_q;
    assign free_count_o = CNT_W'(count);
    assign free_valid_o = (count != '0);
    assign full_o       = (count == PW'(DEPTH));
    assign free_reg_o   = fifo_q[spec_head_q[PTR_W-1:0]];
    assign error_o      = error_q;

`ifdef FREE_LIST_CHECK_EN
    logic [PHYS_REG_SZ-1:0] is_free_q, is_free_d;
    logic [PW-1:0]          squash_n;
`endif

    always_comb begin
        alloc_req  = alloc_en_i && !rollback_i;
        alloc_take = alloc_req && free_valid_o;
        alloc_err  = alloc_req && !free_valid_o;

        // Retire with nothing speculative outstanding is a protocol fault.
        retire_err = retire_en_i && (arch_head_q == spec_head_q);
        retire_ok  = retire_en_i && !retire_err;
        push_req   = retire_ok && (retire_told_i != '0);
        push_err   = push_req && full_o && !alloc_take;
        push       = push_req && !push_err;

        arch_head_d = arch_head_q + PW'(retire_ok);
        tail_d      = tail_q + PW'(push);
        spec_head_d = rollback_i ? arch_head_d : spec_head_q + PW'(alloc_take);

        check_err = 1'b0;
`ifdef FREE_LIST_CHECK_EN
        is_free_d = is_free_q;
        squash_n  = spec_head_q - arch_head_d;
        if (alloc_take) begin
            if (!is_free_q[free_reg_o]) check_err = 1'b1;
            is_free_d[free_reg_o] = 1'b0;
        end
        if (push) begin
            if (is_free_q[retire_told_i]) check_err = 1'b1;
            is_free_d[retire_told_i] = 1'b1;
        end
        if (rollback_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (PW'(i) < squash_n)
                    is_free_d[fifo_q[arch_head_d[PTR_W-1:0] + PTR_W'(i)]] = 1'b1;
            end
        end
`endif

        error_d = error_q | alloc_err | retire_err | push_err | check_err;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++)
                fifo_q[i] <= PREG_W'(ARCH_REG_SZ + i);
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= PW'(DEPTH);
            error_q     <= 1'b0;
        end else begin
            if (push)
                fifo_q[tail_q[PTR_W-1:0]] <= retire_told_i;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            error_q     <= error_d;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < PHYS_REG_SZ; i++)
                is_free_q[i] <= (i >= ARCH_REG_SZ);
        end else begin
            is_free_q <= is_free_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
// ============================================================================
// Module   : tb_free_list
// Purpose  : Directed self-checking bench for free_list.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_free_list;

    logic       clock_i;
    logic       reset_i;
    logic       alloc_en_i;
    logic [5:0] free_reg_o;
    logic       free_valid_o;
    logic       retire_en_i;
    logic [5:0] retire_told_i;
    logic       rollback_i;
    logic [5:0] free_count_o;
    logic       full_o;
    logic       error_o;

    int n_checks = 0;
    int n_fail   = 0;

    free_list #(.PHYS_REG_SZ(64), .ARCH_REG_SZ(32)) u_dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .alloc_en_i    (alloc_en_i),
        .free_reg_o    (free_reg_o),
        .free_valid_o  (free_valid_o),
        .retire_en_i   (retire_en_i),
        .retire_told_i (retire_told_i),
        .rollback_i    (rollback_i),
        .free_count_o  (free_count_o),
        .full_o        (full_o),
        .error_o       (error_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        alloc_en_i    = 1'b0;
        retire_en_i   = 1'b0;
        retire_told_i = '0;
        rollback_i    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        alloc_en_i = 1'b1;
        for (int k = 0; k < n; k++) tick();
        alloc_en_i = 1'b0;
    endtask

    initial begin
        idle();
        reset_i = 1'b1;

        // Reset image
        do_reset();
        tick();
        check("rst_free_reg",   free_reg_o,   32);
        check("rst_free_valid", free_valid_o, 1);
        check("rst_free_count", free_count_o, 32);
        check("rst_full",       full_o,       1);
        check("rst_error",      error_o,      0);

        // Three allocations, one retire, then drain to the recycled register
        alloc_en_i = 1'b1;
        tick(); check("a1_free_reg", free_reg_o, 33);
        tick(); check("a2_free_reg", free_reg_o, 34);
        tick(); check("a3_free_reg", free_reg_o, 35);
        alloc_en_i = 1'b0;
        check("a3_count", free_count_o, 29);
        check("a3_full",  full_o,       0);
        retire_en_i = 1'b1; retire_told_i = 6'd5;
        tick();
        idle();
        check("ret5_count", free_count_o, 30);
        alloc_n(29);
        check("wrap_free_reg", free_reg_o,   5);
        check("wrap_count",    free_count_o, 1);
        check("wrap_error",    error_o,      0);

        // Drain to empty, then alloc while empty
        do_reset();
        alloc_n(32);
        check("empty_valid", free_valid_o, 0);
        check("empty_count", free_count_o, 0);
        check("empty_error", error_o,      0);
        alloc_n(1);
        check("emptyalloc_error", error_o,      1);
        check("emptyalloc_count", free_count_o, 0);
        check("emptyalloc_valid", free_valid_o, 0);

        // Alloc 4, retire one, rollback restores the squashed three
        do_reset();
        alloc_n(4);
        check("rb_pre_reg",   free_reg_o,   36);
        check("rb_pre_count", free_count_o, 28);
        retire_en_i = 1'b1; retire_told_i = 6'd7;
        tick();
        idle();
        check("rb_ret_count", free_count_o, 29);
        rollback_i = 1'b1;
        tick();
        idle();
        check("rb_free_reg", free_reg_o,   33);
        check("rb_count",    free_count_o, 32);
        check("rb_error",    error_o,      0);
        // Nothing speculative left: retire is a protocol fault and changes nothing
        retire_en_i = 1'b1; retire_told_i = 6'd8;
        tick();
        idle();
        check("badret_error", error_o,      1);
        check("badret_count", free_count_o, 32);

        // Same-cycle alloc+retire, then alloc+rollback, then zero-register retire
        do_reset();
        alloc_n(2);
        alloc_en_i = 1'b1; retire_en_i = 1'b1; retire_told_i = 6'd9;
        tick();
        idle();
        check("ar_count",    free_count_o, 30);
        check("ar_free_reg", free_reg_o,   35);
        alloc_en_i = 1'b1; rollback_i = 1'b1;
        tick();
        idle();
        check("arb_free_reg", free_reg_o,   33);
        check("arb_count",    free_count_o, 32);
        check("arb_error",    error_o,      0);
        alloc_n(1);
        check("z_pre_count", free_count_o, 31);
        retire_en_i = 1'b1; retire_told_i = 6'd0;
        tick();
        idle();
        check("zret_count", free_count_o, 31);
        check("zret_error", error_o,      0);

        // Releasing a register that is still on the list
        do_reset();
        alloc_n(1);
        retire_en_i = 1'b1; retire_told_i = 6'd40;
        tick();
        idle();
`ifdef FREE_LIST_CHECK_EN
        check("dblfree_error", error_o, 1);
`else
        check("dblfree_error", error_o, 0);
`endif
        do_reset();
        check("rst2_error", error_o,      0);
        check("rst2_count", free_count_o, 32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
